// File: rtl/cpu_pkg.sv
// Shared SAP CPU definitions: data word width and default input FIFO depth.
package cpu_pkg;

    localparam int WORD_W   = 4;
    localparam int IN_DEPTH = 4;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/cpu_in_port_if.sv
// Producer-side valid/ready handshake into the CPU input port.
interface cpu_in_port_if #(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/cpu_in_fifo.sv
// Small FIFO behind the CPU input port; occupancy is tracked by count.
module cpu_in_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !rst;
    assign do_pop  = pop && !empty && !rst;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_in_port.sv
// SAP CPU 4-bit input port: handshake FIFO, popped once per rising edge of en.
// Define CPU_IN_PORT_UF_EN to add the sticky underflow flag in_uf.
module cpu_in_port
    import cpu_pkg::*;
#(
    parameter int DEPTH = IN_DEPTH,
    parameter int WIDTH = WORD_W
) (
    input  logic                       clk,
    input  logic                       rst,
    cpu_in_port_if.slave               bus,
    input  logic                       en,
    output logic [WIDTH-1:0]           port_in_out,
    output logic                       in_avail,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef CPU_IN_PORT_UF_EN
    ,
    output logic                       in_uf
`endif
);

    logic en_q;
    logic rise;
    logic push;
    logic pop;
    logic full;
    logic empty;

    assign bus.in_ready = !full && !rst;
    assign push         = bus.in_valid && bus.in_ready;
    assign rise         = en && !en_q;
    assign pop          = rise && !empty && !rst;
    assign in_avail     = !empty;

    // Held high through reset so an en spanning reset release cannot pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q <= 1'b1;
        end else begin
            en_q <= en;
        end
    end

`ifdef CPU_IN_PORT_UF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            in_uf <= 1'b0;
        end else if (rise && empty) begin
            in_uf <= 1'b1;
        end
    end
`endif

    cpu_in_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (bus.in_data),
        .rdata (port_in_out),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_cpu_in_port.sv
// Scoreboard bench for cpu_in_port: directed scenarios then random traffic.
module tb_cpu_in_port;
    import cpu_pkg::*;

    localparam int DEPTH = IN_DEPTH;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    word_t      port_in_out;
    logic       in_avail;
    logic [2:0] count;
`ifdef CPU_IN_PORT_UF_EN
    logic       in_uf;
`endif

    cpu_in_port_if #(.WIDTH(WORD_W)) bus ();

    cpu_in_port #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .en          (en),
        .port_in_out (port_in_out),
        .in_avail    (in_avail),
        .count       (count)
`ifdef CPU_IN_PORT_UF_EN
        ,
        .in_uf       (in_uf)
`endif
    );

    always #5 clk = ~clk;

    int vecs  = 0;
    int fails = 0;

    // Reference model state (contents of the port as seen by the CPU).
    word_t mq[$];
    word_t exp_q[$];
    logic  m_enq = 1'b1;
    logic  m_uf  = 1'b0;
    logic  armed = 1'b0;

    logic  cur_v = 1'b0;
    word_t cur_d = '0;
    logic  cur_e = 1'b0;
    logic  cur_r = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (cur_r) begin
            mq.delete();
            m_enq = 1'b1;
            m_uf  = 1'b0;
        end else begin
            bit rise_m;
            bit room;
            rise_m = cur_e && !m_enq;
            room   = mq.size() < DEPTH;
            if (rise_m && mq.size() == 0) m_uf = 1'b1;
            if (rise_m && mq.size() > 0) void'(mq.pop_front());
            if (cur_v && room) mq.push_back(cur_d);
            m_enq = cur_e;
        end
    endtask

    task automatic step(input logic v, input word_t d, input logic e, input logic r);
        @(posedge clk);
        #1;
        model_edge();
        armed = 1'b1;
        cur_v = v;
        cur_d = d;
        cur_e = e;
        cur_r = r;
        bus.in_valid = v;
        bus.in_data  = d;
        en  = e;
        rst = r;
        if (!r && e && !m_enq && mq.size() > 0) exp_q.push_back(mq[0]);
    endtask

    // Monitor: checks visible state mid-cycle and scores every word the CPU reads.
    logic p_en  = 1'b0;
    logic p_rst = 1'b1;
    always @(negedge clk) begin
        if (armed) begin
            bit rise_o;
            chk("count", 32'(count), mq.size());
            chk("in_avail", 32'(in_avail), int'(mq.size() > 0));
            chk("in_ready", 32'(bus.in_ready), int'(!rst && mq.size() < DEPTH));
            chk("port_in_out", 32'(port_in_out), (mq.size() > 0) ? int'(mq[0]) : 0);
`ifdef CPU_IN_PORT_UF_EN
            chk("in_uf", 32'(in_uf), int'(m_uf));
`endif
            rise_o = en && !(p_rst ? 1'b1 : p_en);
            if (rise_o && in_avail && !rst) begin
                if (exp_q.size() == 0) begin
                    vecs++;
                    fails++;
                    $display("FAIL pop_unexpected: got %0d expected none at %0t", port_in_out, $time);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    chk("pop_data", 32'(port_in_out), int'(w));
                end
            end
        end
        p_en  = en;
        p_rst = rst;
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // 1: reset, single push, single read
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 4'hA, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // 2: fill to full, hold off a fifth word, read four in order
        for (int i = 1; i <= 4; i++) step(1, word_t'(i), 0, 0);
        step(1, 4'h5, 0, 0);
        step(1, 4'h5, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0);
            step(0, 0, 0, 0);
        end

        // 3: en held five cycles with two entries pops once
        step(1, 4'hB, 0, 0);
        step(1, 4'hC, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // 4: push+pop while full, then wrap with interleaved traffic
        for (int i = 1; i <= 4; i++) step(1, word_t'(i + 8), 0, 0);
        step(1, 4'hD, 1, 0);
        step(1, 4'hD, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0);
            step(0, 0, 0, 0);
        end
        for (int i = 0; i < 8; i++) begin
            step(1, word_t'(i), 0, 0);
            step(0, 0, 1, 0);
            step(0, 0, 0, 0);
        end

        // 5: read while empty, with and without a simultaneous push
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(1, 4'h6, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // 6: reset with en held high, no pop until en re-rises
        for (int i = 1; i <= 4; i++) step(1, word_t'(i), 0, 0);
        step(0, 0, 1, 0);
        step(1, 4'hE, 1, 1);
        step(0, 0, 1, 0);
        step(1, 4'h7, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) != 0),
                 word_t'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 39) == 0));
        end

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("reads_outstanding", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
